// File: rtl/pixel_out_serializer_pkg.sv
// pixel_out_serializer_pkg: shared widths, mode encodings and serializer state type
package pixel_out_serializer_pkg;

    localparam int MAX_PIXEL_BITS = 24;
    localparam int BYTE_WIDTH = 8;
    localparam int SER_FIFO_DEPTH = 4;

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_SOBEL = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    typedef enum logic {IDLE, SEND} ser_state_t;

endpackage

// File: rtl/pixel_out_serializer_fifo.sv
// px_fifo: generic synchronous FIFO with extra-MSB pointers and head read-out
module px_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // pointer advance; the extra MSB separates full from empty
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage; a push while full only happens alongside a pop of that same slot
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_out_serializer.sv
// pixel_out_serializer: buffers pixels and emits them as 1 or 3 bytes over valid/ready
module pixel_out_serializer
    import pixel_out_serializer_pkg::*;
#(
    parameter int MAX_PIXEL_BITS = pixel_out_serializer_pkg::MAX_PIXEL_BITS,
    parameter int BYTE_WIDTH = pixel_out_serializer_pkg::BYTE_WIDTH,
    parameter int FIFO_DEPTH = SER_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                select_i,
    input  logic                      px_rdy_i,
    input  logic [MAX_PIXEL_BITS-1:0] in_pixel_i,
    input  logic                      byte_ready_i,
    output logic [BYTE_WIDTH-1:0]     byte_o,
    output logic                      byte_valid_o,
    output logic                      last_byte_o,
    output logic                      fifo_full_o,
    output logic                      overflow_o,
    input  logic                      clear_overflow_i
);

    localparam int NB = MAX_PIXEL_BITS / BYTE_WIDTH;
    localparam int NW = $clog2(NB + 1);
    localparam int EW = MAX_PIXEL_BITS + NW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ser_state_t state;
    logic [NW-1:0] idx;
    logic [NW-1:0] nb_in;
    logic [NW-1:0] head_nb;
    logic [NW-1:0] sh;
    logic [MAX_PIXEL_BITS-1:0] head_px;
    logic [EW-1:0] head;
    logic [CW-1:0] count;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last;
    logic drop;

    assign nb_in = select_i == MODE_BYPASS ? NW'(NB) : NW'(1);
    assign head_px = head[EW-1:NW];
    assign head_nb = head[NW-1:0];
    assign last = idx == head_nb - NW'(1);
    assign pop = state == SEND && byte_ready_i && last;
    assign push = px_rdy_i && (!full || pop);
    assign drop = px_rdy_i && full && !pop;
    assign sh = head_nb - idx - NW'(1);

    assign byte_valid_o = state == SEND;
    assign byte_o = byte_valid_o ? BYTE_WIDTH'(head_px >> (int'(sh) * BYTE_WIDTH)) : '0;
    assign last_byte_o = byte_valid_o && last;
    assign fifo_full_o = full;

    px_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push   (push),
        .pop    (pop),
        .wdata  ({in_pixel_i, nb_in}),
        .rdata  (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // byte sequencer: walks the head entry MSB first, pops on its last byte
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            idx <= '0;
        end else if (state == IDLE) begin
            state <= (push || !empty) ? SEND : IDLE;
        end else if (byte_ready_i) begin
            idx <= last ? '0 : idx + 1'b1;
            state <= (last && count == CW'(1) && !push) ? IDLE : SEND;
        end
    end

    // sticky drop flag; a new drop wins over a simultaneous clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) overflow_o <= 1'b0;
        else overflow_o <= drop || (overflow_o && !clear_overflow_i);
    end

endmodule
